// File: rtl/semafor_pkg.sv
// Shared types and constants for the pedestrian-crossing controller path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package semafor_pkg;

    // Debounce FSM encoding: bit 1 is the accepted level, bit 0 marks a pending confirmation.
    typedef enum logic [1:0] {
        REPAUS         = 2'b00,
        CONF_APASARE   = 2'b01,
        APASAT         = 2'b10,
        CONF_ELIBERARE = 2'b11
    } stare_t;

    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int NR_APASARI_W     = 8;

endpackage

// File: rtl/buton_debounce_if.sv
// Button conditioner signal bundle: raw pad/ack in, clean level/pulse/request/count out.
// Latency: n/a (wires only).
// Backpressure: none; ack is the only return path from the controller.
// Ports: master = pad + controller side, slave = debounce block.
interface buton_debounce_if;
    import semafor_pkg::*;

    logic                    buton_raw;
    logic                    ack;
    logic                    buton_curat;
    logic                    buton_puls;
    logic                    cerere;
    logic [NR_APASARI_W-1:0] nr_apasari;

    modport master (
        output buton_raw,
        output ack,
        input  buton_curat,
        input  buton_puls,
        input  cerere,
        input  nr_apasari
    );

    modport slave (
        input  buton_raw,
        input  ack,
        output buton_curat,
        output buton_puls,
        output cerere,
        output nr_apasari
    );

endinterface

// File: rtl/sincronizator.sv
// Two-flop synchronizer for an asynchronous pad input.
// Latency: 2 clk from pad to q.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), d (async pad), q (synchronized level).
module sincronizator (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/buton_debounce.sv
// Pedestrian button conditioner: sync, per-level debounce, press pulse, held request, press count.
// Latency: DEBOUNCE_CYC+3 clk from clean pad edge to buton_puls/buton_curat/cerere.
// Backpressure: none; cerere is held until ack, further presses do not queue.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of buton_debounce_if).
module buton_debounce
    import semafor_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    buton_debounce_if.slave  bus
);

    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
    localparam logic [NR_APASARI_W-1:0] NR_ONE  = NR_APASARI_W'(1);

    logic                    s2;
    stare_t                  stare;
    stare_t                  stare_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;
    logic                    curat_q;
    logic                    puls_q;
    logic                    cerere_q;
    logic [NR_APASARI_W-1:0] nr_q;

    sincronizator u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.buton_raw),
        .q     (s2)
    );

    // Entry into a confirm state counts as the first stable sample, so the
    // counter starts at 1 and acceptance happens when it reaches CNT_MAX.
    always_comb begin
        stare_next = stare;
        cnt_next   = cnt;
        accept     = 1'b0;
        unique case (stare)
            REPAUS: begin
                if (s2) begin
                    stare_next = CONF_APASARE;
                    cnt_next   = CNT_ONE;
                end
            end
            CONF_APASARE: begin
                if (!s2) begin
                    stare_next = REPAUS;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    stare_next = APASAT;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            APASAT: begin
                if (!s2) begin
                    stare_next = CONF_ELIBERARE;
                    cnt_next   = CNT_ONE;
                end
            end
            CONF_ELIBERARE: begin
                if (s2) begin
                    stare_next = APASAT;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    stare_next = REPAUS;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stare    <= REPAUS;
            cnt      <= '0;
            curat_q  <= 1'b0;
            puls_q   <= 1'b0;
            cerere_q <= 1'b0;
            nr_q     <= '0;
        end else begin
            stare    <= stare_next;
            cnt      <= cnt_next;
            curat_q  <= (stare_next == APASAT) || (stare_next == CONF_ELIBERARE);
            puls_q   <= accept;
            // Request rises together with the pulse and is re-set while the pulse
            // is high, so an ack landing on the pulse cycle cannot drop a fresh press.
            cerere_q <= accept | puls_q | (cerere_q & ~bus.ack);
            if (puls_q) begin
                nr_q <= nr_q + NR_ONE;
            end
        end
    end

    assign bus.buton_curat = curat_q;
    assign bus.buton_puls  = puls_q;
    assign bus.cerere      = cerere_q;
    assign bus.nr_apasari  = nr_q;

endmodule

// File: tb/tb_buton_debounce.sv
module tb_buton_debounce;
    import semafor_pkg::*;

    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    buton_debounce_if bus ();

    buton_debounce #(.DEBOUNCE_CYC(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.buton_raw = 1'b0;
        bus.ack = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Clean press: raw high before edge 0, the pulse is visible after edge D+2.
    task automatic do_press();
        bus.buton_raw = 1'b1;
        repeat (D + 3) tick();
    endtask

    task automatic do_release();
        bus.buton_raw = 1'b0;
        repeat (D + 4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.buton_raw = 1'b1;
        bus.ack = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (bus.buton_curat !== 1'b0) begin errors++; $display("FAIL reset_curat got %b want 0", bus.buton_curat); end
        if (bus.buton_puls !== 1'b0) begin errors++; $display("FAIL reset_puls got %b want 0", bus.buton_puls); end
        if (bus.cerere !== 1'b0) begin errors++; $display("FAIL reset_cerere got %b want 0", bus.cerere); end
        if (bus.nr_apasari !== 8'd0) begin errors++; $display("FAIL reset_nr got %0d want 0", bus.nr_apasari); end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (bus.buton_puls !== logic'(k == 6)) begin
                errors++;
                $display("FAIL post_reset_puls edge %0d got %b want %b", k, bus.buton_puls, (k == 6));
            end
        end
        checks++;
        if (bus.nr_apasari !== 8'd1) begin errors++; $display("FAIL post_reset_nr got %0d want 1", bus.nr_apasari); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        do_release();
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int pulses;
        apply_reset();
        pat = 5'b01101;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            bus.buton_raw = pat[k];
            tick();
            if (bus.buton_puls === 1'b1) pulses++;
        end
        bus.buton_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.buton_puls === 1'b1) pulses++;
        end
        checks += 4;
        if (pulses != 0) begin errors++; $display("FAIL bounce_pulses got %0d want 0", pulses); end
        if (bus.cerere !== 1'b0) begin errors++; $display("FAIL bounce_cerere got %b want 0", bus.cerere); end
        if (bus.nr_apasari !== 8'd0) begin errors++; $display("FAIL bounce_nr got %0d want 0", bus.nr_apasari); end
        if (bus.buton_curat !== 1'b0) begin errors++; $display("FAIL bounce_curat got %b want 0", bus.buton_curat); end
    endtask

    task automatic test_clean_press();
        int pulses;
        pulses = 0;
        bus.buton_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.buton_puls === 1'b1) pulses++;
            checks++;
            if (bus.buton_curat !== logic'(k >= D + 2)) begin
                errors++;
                $display("FAIL press_curat edge %0d got %b want %b", k, bus.buton_curat, (k >= D + 2));
            end
        end
        bus.buton_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.buton_puls === 1'b1) pulses++;
            checks++;
            if (bus.buton_curat !== logic'(k < D + 2)) begin
                errors++;
                $display("FAIL release_curat edge %0d got %b want %b", k, bus.buton_curat, (k < D + 2));
            end
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL clean_pulses got %0d want 1", pulses); end
        if (bus.cerere !== 1'b1) begin errors++; $display("FAIL clean_cerere_held got %b want 1", bus.cerere); end
        if (bus.nr_apasari !== 8'd1) begin errors++; $display("FAIL clean_nr got %0d want 1", bus.nr_apasari); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++;
        if (bus.cerere !== 1'b0) begin errors++; $display("FAIL clean_ack got %b want 0", bus.cerere); end
    endtask

    task automatic test_simul_ack();
        do_press();
        checks++;
        if (bus.buton_puls !== 1'b1) begin errors++; $display("FAIL simul_puls got %b want 1", bus.buton_puls); end
        bus.ack = 1'b1;
        tick();
        checks++;
        if (bus.cerere !== 1'b1) begin errors++; $display("FAIL simul_set_wins got %b want 1", bus.cerere); end
        tick();
        bus.ack = 1'b0;
        checks += 2;
        if (bus.cerere !== 1'b0) begin errors++; $display("FAIL simul_second_ack got %b want 0", bus.cerere); end
        if (bus.nr_apasari !== 8'd2) begin errors++; $display("FAIL simul_nr got %0d want 2", bus.nr_apasari); end
        do_release();
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 255; i++) begin
            do_press();
            do_release();
        end
        checks += 2;
        if (bus.nr_apasari !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", bus.nr_apasari); end
        if (bus.cerere !== 1'b1) begin errors++; $display("FAIL wrap_cerere_held got %b want 1", bus.cerere); end
        do_press();
        do_release();
        checks += 2;
        if (bus.nr_apasari !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", bus.nr_apasari); end
        if (bus.cerere !== 1'b1) begin errors++; $display("FAIL wrap_cerere got %b want 1", bus.cerere); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.cerere !== 1'b0) begin errors++; $display("FAIL wrap_no_queue got %b want 0", bus.cerere); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        bus.buton_raw = 1'b1;
        repeat (5) tick();
        checks += 2;
        if (dut.stare !== CONF_APASARE) begin errors++; $display("FAIL mid_pre_state got %0d want %0d", dut.stare, CONF_APASARE); end
        if (dut.cnt !== 3'd3) begin errors++; $display("FAIL mid_pre_cnt got %0d want 3", dut.cnt); end
        rst_n = 1'b0;
        bus.buton_raw = 1'b0;
        tick();
        rst_n = 1'b1;
        checks += 3;
        if (dut.stare !== REPAUS) begin errors++; $display("FAIL mid_state got %0d want %0d", dut.stare, REPAUS); end
        if (dut.cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", dut.cnt); end
        if (bus.buton_puls !== 1'b0) begin errors++; $display("FAIL mid_puls got %b want 0", bus.buton_puls); end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.buton_puls === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses != 0) begin errors++; $display("FAIL mid_pulses got %0d want 0", pulses); end
        if (bus.nr_apasari !== 8'd0) begin errors++; $display("FAIL mid_nr got %0d want 0", bus.nr_apasari); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.buton_raw = 1'b0;
        bus.ack = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_simul_ack();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
